pwm_breath_ramp: RTL and testbench
==================================

# pwm_breath_ramp

Upstream duty-cycle source for the PWM LED driver. Generates a triangular "breathing" duty value that ramps from 0 to full scale and back, advancing only at PWM period boundaries so the downstream PWM comparator never sees a mid-period duty change. Output `duty` connects directly to the PWM block's duty input (`pwm_inp`). The PWM block supplies `period_done` from its counter wrap.

## Interface
- `WIDTH`, 8: duty width in bits. Full scale is MAX = 2^WIDTH-1.
- `STEP`, 1: duty increment/decrement per step. Constraint: 1 ≤ STEP ≤ MAX.
- `PERIODS_PER_STEP`, 4: qualified PWM periods per duty step. Constraint: ≥1.
- `HOLD_PERIODS`, 16: qualified periods spent at each extreme. Only used with `BREATH_HOLD_EN`. Constraint: ≥1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: ramp enable. When low, all state is frozen.
- `period_done` in 1: one-cycle pulse from the PWM block at counter wrap.
- `duty` out WIDTH: current duty value, registered.
- `duty_update` out 1: one-cycle pulse, coincident with a changed `duty` value.
- `dir` out 1: 1 = next/current motion is upward, 0 = downward.

## Operation
- Event: a cycle with `en && period_done`. Only events advance counters or the FSM. `period_done` is ignored when `en` is low or `reset` is high.
- States: RISE, HOLD_HIGH, FALL, HOLD_LOW. `dir` is 1 in RISE and HOLD_LOW, 0 in FALL and HOLD_HIGH.
- RISE/FALL:
  - Each event increments `step_cnt`.
  - On the event where `step_cnt == PERIODS_PER_STEP-1`: clear `step_cnt` and take a step.
- Step arithmetic is computed in WIDTH+1 bits and saturates:
  - RISE: if duty+STEP ≥ MAX, set duty=MAX and leave RISE. Otherwise duty += STEP.
  - FALL: if duty ≤ STEP, set duty=0 and leave FALL. Otherwise duty -= STEP.
- Leaving RISE goes to HOLD_HIGH (macro defined) or FALL (macro undefined). Leaving FALL goes to HOLD_LOW or RISE, likewise.
- HOLD states:
  - Each event increments `hold_cnt`.
  - On the event where `hold_cnt == HOLD_PERIODS-1`: clear `hold_cnt`, and go HOLD_HIGH→FALL or HOLD_LOW→RISE.
  - `step_cnt` stays 0 throughout. `duty` is unchanged.
- `duty_update` is 1 for exactly the cycle after any edge where the `duty` register changed value. It is 0 otherwise, including at transitions that leave `duty` unchanged.
- PERIODS_PER_STEP=1 steps on every event.
- If STEP=MAX, the ramp alternates 0↔MAX.

## Timing
- Reset values: `duty`=0, `duty_update`=0, `dir`=1, state=RISE, `step_cnt`=0, `hold_cnt`=0.
- Latency: an event sampled at edge N produces the new `duty`, `dir` and `duty_update` after edge N, visible in cycle N+1. This is one clock, ahead of the PWM's next period start.
- Reset asserted mid-ramp or mid-hold: every output and counter returns to its reset value at the next edge, regardless of `en` or `period_done`.
- Reset and `period_done` in the same cycle: reset wins and the event is discarded.
- `en` deasserted: `duty`, `dir`, state and counters are held. `duty_update` is 0. On re-enable, counting resumes from the held counts.
- `period_done` held high for k cycles counts as k events. The PWM contract is single-cycle pulses.

## Configuration
- `BREATH_HOLD_EN`:
  - Defined: HOLD_HIGH and HOLD_LOW are compiled in. Duty dwells at MAX and at 0 for HOLD_PERIODS events each.
  - Undefined: hold states and `hold_cnt` are removed. Direction reverses on the same edge that saturates duty, and the next step occurs PERIODS_PER_STEP events later. `HOLD_PERIODS` is unused.

## Test plan
All scenarios use WIDTH=8, STEP=16, PERIODS_PER_STEP=2, HOLD_PERIODS=3, `en`=1, single-cycle `period_done` pulses every 10 cycles.
- Reset, then 2 pulses -> `duty` goes 0→16 one cycle after the 2nd pulse. `duty_update` pulses exactly once. `dir`=1.
- Ramp up from 0, 32 pulses -> duty climbs 16,32,…,240, then 255 (saturated) on pulse 32. `dir` drops to 0 on that edge.
- With `BREATH_HOLD_EN`, continue from 255 -> duty holds at 255 for 3 pulses with no `duty_update`. Two further pulses then give 239.
- Without `BREATH_HOLD_EN`, from duty=16 in FALL -> the 2nd pulse gives duty=0 and `dir`=1. Two more pulses give 16.
- `en`=0 while 10 pulses arrive at duty=128 -> `duty` stays 128 with no `duty_update`. After `en`=1, the step occurs on the count continuing from the held `step_cnt`.
- `reset` asserted for one cycle at duty=128 coincident with a pulse -> the next cycle shows `duty`=0, `dir`=1, `duty_update`=0. Two subsequent pulses give 16.

Source files
------------

// File: rtl/pwm_breath_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_breath_ramp
//  Purpose  : Triangular "breathing" duty-cycle source for a PWM LED driver.
//             Duty ramps 0 -> MAX -> 0, advancing only on PWM period
//             boundaries, so the downstream comparator never sees a
//             mid-period change.
//  Ports    : clk          - single clock, rising edge
//             reset        - synchronous, active-high reset
//             en           - ramp enable; low freezes all state
//             period_done  - one-cycle pulse at PWM counter wrap
//             duty         - registered duty value (WIDTH bits)
//             duty_update  - one-cycle pulse coincident with a new duty
//             dir          - 1 = upward motion (RISE / HOLD_LOW)
//  Options  : BREATH_HOLD_EN - when defined, duty dwells at MAX and at 0
//             for HOLD_PERIODS qualified periods before reversing.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_breath_ramp #(
    parameter int WIDTH            = 8,
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 4,
    parameter int HOLD_PERIODS     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             period_done,
    output logic [WIDTH-1:0] duty,
    output logic             duty_update,
    output logic             dir
);

    // Step arithmetic runs in WIDTH+1 bits so the saturation compare
    // sees the carry out of duty+STEP.
    localparam logic [WIDTH:0]   C_MAX    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   C_STEP   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] C_STEP_W = WIDTH'(STEP);

    localparam int SCW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [SCW-1:0] C_STEP_LAST = SCW'(PERIODS_PER_STEP - 1);

    // Elaboration-time parameter sanity checks. An illegal setting leaves
    // an empty labelled block that is easy to spot in the elaborated tree.
    if (STEP < 1 || STEP > (2**WIDTH - 1)) begin : g_bad_step
    end
    if (PERIODS_PER_STEP < 1) begin : g_bad_periods_per_step
    end
    if (HOLD_PERIODS < 1) begin : g_bad_hold_periods
    end

    typedef enum logic [1:0] {
        S_RISE      = 2'd0,
        S_HOLD_HIGH = 2'd1,
        S_FALL      = 2'd2,
        S_HOLD_LOW  = 2'd3
    } state_t;

`ifdef BREATH_HOLD_EN
    localparam state_t C_AFTER_RISE = S_HOLD_HIGH;
    localparam state_t C_AFTER_FALL = S_HOLD_LOW;

    localparam int HCW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [HCW-1:0] C_HOLD_LAST = HCW'(HOLD_PERIODS - 1);

    logic [HCW-1:0] r_hold_cnt;
    logic [HCW-1:0] w_hold_nx;
`else
    // Without dwell, direction reverses on the saturating edge itself.
    localparam state_t C_AFTER_RISE = S_FALL;
    localparam state_t C_AFTER_FALL = S_RISE;
`endif

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] w_duty_nx;
    logic [SCW-1:0]   r_step_cnt;
    logic [SCW-1:0]   w_step_nx;
    logic             r_duty_update;

    logic             w_event;
    logic [WIDTH:0]   w_sum;
    logic             w_step_due;

    assign w_event    = en & period_done;
    assign w_sum      = {1'b0, r_duty} + C_STEP;
    assign w_step_due = (r_step_cnt == C_STEP_LAST);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_step_nx  = r_step_cnt;
`ifdef BREATH_HOLD_EN
        w_hold_nx  = r_hold_cnt;
`endif
        if (w_event) begin
            case (r_state)
                S_RISE: begin
                    if (w_step_due) begin
                        w_step_nx = '0;
                        if (w_sum >= C_MAX) begin
                            w_duty_nx  = C_MAX[WIDTH-1:0];
                            w_state_nx = C_AFTER_RISE;
                        end else begin
                            w_duty_nx = w_sum[WIDTH-1:0];
                        end
                    end else begin
                        w_step_nx = r_step_cnt + SCW'(1);
                    end
                end
                S_FALL: begin
                    if (w_step_due) begin
                        w_step_nx = '0;
                        if ({1'b0, r_duty} <= C_STEP) begin
                            w_duty_nx  = '0;
                            w_state_nx = C_AFTER_FALL;
                        end else begin
                            w_duty_nx = r_duty - C_STEP_W;
                        end
                    end else begin
                        w_step_nx = r_step_cnt + SCW'(1);
                    end
                end
`ifdef BREATH_HOLD_EN
                S_HOLD_HIGH, S_HOLD_LOW: begin
                    // step_cnt was cleared on entry and stays 0 here.
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        w_hold_nx  = '0;
                        w_state_nx = (r_state == S_HOLD_HIGH) ? S_FALL : S_RISE;
                    end else begin
                        w_hold_nx = r_hold_cnt + HCW'(1);
                    end
                end
`endif
                default: begin
                    // Hold encodings are unreachable without dwell support;
                    // recover into RISE if ever seen.
                    w_state_nx = S_RISE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_RISE;
            r_duty        <= '0;
            r_step_cnt    <= '0;
            r_duty_update <= 1'b0;
`ifdef BREATH_HOLD_EN
            r_hold_cnt    <= '0;
`endif
        end else begin
            r_state       <= w_state_nx;
            r_duty        <= w_duty_nx;
            r_step_cnt    <= w_step_nx;
            // Flags only real changes: a saturated step or a hold-exit
            // that leaves duty as-is produces no pulse.
            r_duty_update <= (w_duty_nx != r_duty);
`ifdef BREATH_HOLD_EN
            r_hold_cnt    <= w_hold_nx;
`endif
        end
    end

    assign duty        = r_duty;
    assign duty_update = r_duty_update;
    assign dir         = (r_state == S_RISE) || (r_state == S_HOLD_LOW);

endmodule
`default_nettype wire

// File: tb/tb_pwm_breath_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_breath_ramp
//  Purpose  : Self-checking bench for pwm_breath_ramp (WIDTH=8, STEP=16,
//             PERIODS_PER_STEP=2, HOLD_PERIODS=3). Each vector drives one
//             cycle of {reset, en, period_done}, checks the outputs one
//             edge later, then checks that duty_update has dropped and duty
//             is stable on the following edge, then idles to a 10-cycle slot.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_breath_ramp;

    logic       clk;
    logic       reset;
    logic       en;
    logic       period_done;
    logic [7:0] duty;
    logic       duty_update;
    logic       dir;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       pd;
        logic [7:0] exp_duty;
        logic       exp_upd;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[$];

    pwm_breath_ramp #(
        .WIDTH            (8),
        .STEP             (16),
        .PERIODS_PER_STEP (2),
        .HOLD_PERIODS     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .period_done (period_done),
        .duty        (duty),
        .duty_update (duty_update),
        .dir         (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic p,
                       input int d, input logic u, input logic dr);
        vec_t v;
        v.rst = r; v.en = e; v.pd = p;
        v.exp_duty = 8'(d); v.exp_upd = u; v.exp_dir = dr;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; en = v.en; period_done = v.pd;
        @(posedge clk); #1;
        chk("duty",        idx, 32'(duty),        32'(v.exp_duty));
        chk("duty_update", idx, 32'(duty_update), 32'(v.exp_upd));
        chk("dir",         idx, 32'(dir),         32'(v.exp_dir));
        @(negedge clk);
        reset = 1'b0; period_done = 1'b0;
        @(posedge clk); #1;
        chk("upd_drop",    idx, 32'(duty_update), 32'd0);
        chk("duty_stable", idx, 32'(duty),        32'(v.exp_duty));
        repeat (8) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; period_done = 1'b0;

        // Reset coincident with a pulse: reset wins.
        add(1, 1, 1, 0, 0, 1);

        // Ramp up: +16 every 2nd pulse, saturate to 255 on pulse 32.
        for (int p = 1; p <= 32; p++)
            add(0, 1, 1, (p < 32) ? 16 * (p / 2) : 255, (p % 2) == 0, p < 32);

`ifdef BREATH_HOLD_EN
        // Dwell at 255 for 3 pulses, no update, dir already 0.
        for (int h = 0; h < 3; h++) add(0, 1, 1, 255, 0, 0);
`endif
        add(0, 1, 1, 255, 0, 0);
        add(0, 1, 1, 239, 1, 0);

        // Ramp down 239 -> 15.
        for (int q = 1; q <= 28; q++)
            add(0, 1, 1, 239 - 16 * (q / 2), (q % 2) == 0, 0);
        // 15 <= STEP: saturate to 0 and turn upward on the same edge.
        add(0, 1, 1, 15, 0, 0);
        add(0, 1, 1, 0, 1, 1);

`ifdef BREATH_HOLD_EN
        for (int h = 0; h < 3; h++) add(0, 1, 1, 0, 0, 1);
`endif
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 16, 1, 1);

        // Climb to 128, then one extra pulse leaves step_cnt at 1.
        for (int r = 1; r <= 14; r++)
            add(0, 1, 1, 16 + 16 * (r / 2), (r % 2) == 0, 1);
        add(0, 1, 1, 128, 0, 1);

        // Disabled: 10 pulses ignored.
        for (int k = 0; k < 10; k++) add(0, 0, 1, 128, 0, 1);

        // Re-enable: held step_cnt=1 means the very next pulse steps.
        add(0, 1, 1, 144, 1, 1);
        add(0, 1, 1, 144, 0, 1);

        // Reset with a pulse mid-count: everything cleared, count restarts.
        add(1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 16, 1, 1);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
